// File: rtl/bus_ctrl_pkg.sv
// rtl/bus_ctrl_pkg.sv - shared states, regions and default timings for the bus cycle controller
package bus_ctrl_pkg;

  localparam int DEF_CNT_W    = 8;
  localparam int DEF_ROM_WAIT = 1;
  localparam int DEF_RAM_WAIT = 1;
  localparam int DEF_IO_WAIT  = 4;
  localparam int DEF_TIMEOUT  = 200;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_EXT,
    S_ACK,
    S_ERR
  } bus_state_e;

  typedef enum logic [2:0] {
    R_ROM,
    R_RAM,
    R_IO,
    R_DRAM,
    R_CAN,
    R_NONE
  } region_e;

  // Fixed decode priority ROM > RAM > IO > DRAM > CAN
  function automatic region_e decode_region(input logic rom, input logic ram, input logic io,
                                            input logic dram, input logic can);
    if (rom)  return R_ROM;
    if (ram)  return R_RAM;
    if (io)   return R_IO;
    if (dram) return R_DRAM;
    if (can)  return R_CAN;
    return R_NONE;
  endfunction

endpackage

// File: rtl/wait_counter.sv
// rtl/wait_counter.sv - loadable saturating down-counter with zero flag
module wait_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_h_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_h_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bus_cycle_controller.sv
// rtl/bus_cycle_controller.sv - 68000 DTACK/BERR sequencer; BUS_TIMEOUT_EN enables BERR timeouts
import bus_ctrl_pkg::*;

module bus_cycle_controller #(
  parameter int ROM_WAIT = DEF_ROM_WAIT,
  parameter int RAM_WAIT = DEF_RAM_WAIT,
  parameter int IO_WAIT  = DEF_IO_WAIT,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic Clk,
  input  logic Reset_H,
  input  logic AS_L,
  input  logic OnChipRomSelect_H,
  input  logic OnChipRamSelect_H,
  input  logic IOSelect_H,
  input  logic DramSelect_H,
  input  logic CanBusSelect_H,
  input  logic DramReady_H,
  input  logic CanReady_H,
  output logic DTACK_L,
  output logic BERR_L,
  output logic Busy_H
);

  localparam logic [CNT_W-1:0] ROM_LOAD = CNT_W'(ROM_WAIT);
  localparam logic [CNT_W-1:0] RAM_LOAD = CNT_W'(RAM_WAIT);
  localparam logic [CNT_W-1:0] IO_LOAD  = CNT_W'(IO_WAIT);
  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT);

  bus_state_e       state_q, state_d;
  region_e          region_q, region_d;
  region_e          region_start;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             ext_ready;
  logic             dtack_q;

  assign region_start = decode_region(OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H,
                                      DramSelect_H, CanBusSelect_H);

  // Unmapped cycles (R_NONE) see ready stuck at 0
  assign ext_ready = ((region_q == R_DRAM) && DramReady_H) ||
                     ((region_q == R_CAN)  && CanReady_H);

`ifdef BUS_TIMEOUT_EN
  assign cnt_dec = (state_q == S_WAIT) || (state_q == S_EXT);
`else
  assign cnt_dec = (state_q == S_WAIT);
`endif

  always_comb begin
    state_d      = state_q;
    region_d     = region_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state_q)
      S_IDLE: begin
        if (!AS_L) begin
          cnt_load = 1'b1;
          region_d = region_start;
          state_d  = S_WAIT;
          case (region_start)
            R_ROM:   cnt_load_val = ROM_LOAD;
            R_RAM:   cnt_load_val = RAM_LOAD;
            R_IO:    cnt_load_val = IO_LOAD;
            default: begin
              cnt_load_val = TMO_LOAD;
              state_d      = S_EXT;
            end
          endcase
        end
      end
      S_WAIT: begin
        if (AS_L)          state_d = S_IDLE;
        else if (cnt_zero) state_d = S_ACK;
      end
      S_EXT: begin
        if (AS_L)           state_d = S_IDLE;
        else if (ext_ready) state_d = S_ACK;
`ifdef BUS_TIMEOUT_EN
        else if (cnt_zero)  state_d = S_ERR;
`endif
      end
      S_ACK, S_ERR: begin
        if (AS_L) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset_H) begin
      state_q  <= S_IDLE;
      region_q <= R_NONE;
      dtack_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      dtack_q  <= (state_d != S_ACK);
    end
  end

`ifdef BUS_TIMEOUT_EN
  logic berr_q;

  always_ff @(posedge Clk) begin
    if (Reset_H) berr_q <= 1'b1;
    else         berr_q <= (state_d != S_ERR);
  end

  assign BERR_L = berr_q;
`else
  assign BERR_L = 1'b1;
`endif

  assign DTACK_L = dtack_q;
  assign Busy_H  = (state_q != S_IDLE);

  wait_counter #(
    .CNT_W(CNT_W)
  ) u_wait_counter (
    .clk_i     (Clk),
    .rst_h_i   (Reset_H),
    .load_i    (cnt_load),
    .load_val_i(cnt_load_val),
    .dec_i     (cnt_dec),
    .zero_o    (cnt_zero)
  );

endmodule

// File: tb/tb_bus_cycle_controller.sv
// tb/tb_bus_cycle_controller.sv - randomized scoreboard bench for bus_cycle_controller
module tb_bus_cycle_controller;

  localparam int ROM_W = 0;
  localparam int RAM_W = 1;
  localparam int IO_W  = 4;
  localparam int TMO   = 200;
  localparam int CW    = 8;

  logic Clk, Reset_H, AS_L;
  logic RomSel, RamSel, IoSel, DramSel, CanSel;
  logic DramReady, CanReady;
  logic DTACK_L, BERR_L, Busy_H;

  bus_cycle_controller #(
    .ROM_WAIT(ROM_W), .RAM_WAIT(RAM_W), .IO_WAIT(IO_W), .TIMEOUT(TMO), .CNT_W(CW)
  ) dut (
    .Clk(Clk), .Reset_H(Reset_H), .AS_L(AS_L),
    .OnChipRomSelect_H(RomSel), .OnChipRamSelect_H(RamSel), .IOSelect_H(IoSel),
    .DramSelect_H(DramSel), .CanBusSelect_H(CanSel),
    .DramReady_H(DramReady), .CanReady_H(CanReady),
    .DTACK_L(DTACK_L), .BERR_L(BERR_L), .Busy_H(Busy_H)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int edge_n = 0;
  always @(posedge Clk) edge_n++;

`ifdef BUS_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  // kind: 0 = DTACK termination, 1 = BERR termination, 2 = aborted (no termination)
  typedef struct {
    int kind;
    int start;
    int term;
    int rel;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: reconstructs each bus cycle from DUT outputs and scores it
  bit mon_en = 1'b0;
  bit busy_prev = 1'b0;
  int m_start, m_dt, m_be, m_both, stray = 0;

  initial forever begin
    @(negedge Clk);
    if (mon_en) begin
      if (Busy_H && !busy_prev) begin
        m_start = edge_n; m_dt = -1; m_be = -1; m_both = 0;
      end
      if (Busy_H) begin
        if (!DTACK_L && m_dt < 0) m_dt = edge_n;
        if (!BERR_L && m_be < 0)  m_be = edge_n;
        if (!DTACK_L && !BERR_L)  m_both = 1;
      end else if (!DTACK_L || !BERR_L) begin
        stray++;
      end
      if (!Busy_H && busy_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_cycle", 1, 0);
        end else begin
          exp_t e;
          int kact, tact;
          e = exp_q.pop_front();
          kact = (m_dt >= 0) ? 0 : (m_be >= 0) ? 1 : 2;
          tact = (kact == 0) ? m_dt : (kact == 1) ? m_be : -1;
          check("kind", kact, e.kind);
          check("start_edge", m_start, e.start);
          check("term_edge", tact, e.term);
          check("release_edge", edge_n, e.rel);
          check("exclusive", m_both, 0);
          check("idle_outputs", int'({DTACK_L, BERR_L}), 3);
        end
      end
      busy_prev = Busy_H;
    end
  end

  task automatic set_selects(input int r);
    logic [4:0] s;
    s = 5'($urandom);
    for (int j = 0; j < 5; j++) if (j <= r) s[j] = (j == r);
    {CanSel, DramSel, IoSel, RamSel, RomSel} = s;
  endtask

  function automatic int fixed_wait(input int r);
    return (r == 0) ? ROM_W : (r == 1) ? RAM_W : IO_W;
  endfunction

  // r: 0 ROM,1 RAM,2 IO,3 DRAM,4 CAN,5 unmapped; d<0 picks a random ready delay
  task automatic run_cycle(input int r, input bit abort, input int d_in);
    exp_t e;
    int   k, d;
    bit   use_ready;
    @(negedge Clk);
    set_selects(r);
    DramReady = 1'b0; CanReady = 1'b0;
    AS_L = 1'b0;
    k = edge_n + 1;
    e.start = k;
    use_ready = 1'b0;
    d = (d_in < 0) ? $urandom_range(0, 30) : d_in;
    if (r < 3) begin
      int n = fixed_wait(r);
      if (abort && n >= 1) begin
        e.kind = 2; e.term = -1; e.rel = k + 1 + $urandom_range(0, n - 1);
      end else begin
        e.kind = 0; e.term = k + 1 + n; e.rel = e.term + 1 + $urandom_range(0, 3);
      end
    end else if (r < 5 && !abort) begin
      use_ready = 1'b1;
      if (TMO_EN && d > TMO) begin
        e.kind = 1; e.term = k + 1 + TMO;
      end else begin
        e.kind = 0; e.term = k + d + 1;
      end
      e.rel = e.term + 1 + $urandom_range(0, 3);
    end else if (r == 5 && TMO_EN && !abort) begin
      e.kind = 1; e.term = k + 1 + TMO; e.rel = e.term + 1 + $urandom_range(0, 3);
    end else begin
      e.kind = 2; e.term = -1; e.rel = k + 1 + $urandom_range(0, 10);
    end
    exp_q.push_back(e);
    while (edge_n < e.rel - 1) begin
      @(negedge Clk);
      set_selects($urandom_range(0, 5));
      if (r == 3) CanReady = 1'($urandom);
      if (r == 4) DramReady = 1'($urandom);
      if (use_ready && edge_n >= k + d) begin
        if (r == 3) DramReady = 1'b1;
        else        CanReady = 1'b1;
      end
    end
    AS_L = 1'b1;
    DramReady = 1'b0; CanReady = 1'b0;
    {CanSel, DramSel, IoSel, RamSel, RomSel} = '0;
    repeat ($urandom_range(0, 2)) @(negedge Clk);
  endtask

  initial begin
    Reset_H = 1'b1; AS_L = 1'b0;
    {CanSel, DramSel, IoSel, RamSel, RomSel} = 5'b00001;
    DramReady = 1'b0; CanReady = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      check("reset_dtack", int'(DTACK_L), 1);
      check("reset_berr", int'(BERR_L), 1);
      check("reset_busy", int'(Busy_H), 0);
    end
    Reset_H = 1'b0; AS_L = 1'b1;
    {CanSel, DramSel, IoSel, RamSel, RomSel} = '0;
    @(negedge Clk);
    check("idle_busy", int'(Busy_H), 0);
    busy_prev = 1'b0;
    mon_en = 1'b1;

    run_cycle(0, 1'b0, -1);
    run_cycle(1, 1'b0, -1);
    run_cycle(2, 1'b0, -1);
    run_cycle(3, 1'b0, 10);
    run_cycle(4, 1'b0, 0);
    run_cycle(3, 1'b0, TMO);
    run_cycle(2, 1'b1, -1);
    run_cycle(1, 1'b0, -1);
    run_cycle(5, 1'b0, -1);
    run_cycle(4, 1'b1, -1);
    if (TMO_EN) run_cycle(4, 1'b0, TMO + 1);
    for (int i = 0; i < 60; i++) begin
      run_cycle($urandom_range(0, 5), ($urandom_range(0, 3) == 0), -1);
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge Clk);
    check("queue_drained", exp_q.size(), 0);
    check("stray_outputs", stray, 0);
    mon_en = 1'b0;

    // Reset in the middle of an IO cycle
    @(negedge Clk);
    set_selects(2);
    AS_L = 1'b0;
    repeat (2) @(negedge Clk);
    check("midcycle_busy", int'(Busy_H), 1);
    Reset_H = 1'b1;
    @(negedge Clk);
    check("midreset_busy", int'(Busy_H), 0);
    check("midreset_dtack", int'(DTACK_L), 1);
    check("midreset_berr", int'(BERR_L), 1);
    Reset_H = 1'b0; AS_L = 1'b1;
    repeat (2) @(negedge Clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
